// File: rtl/sine_sample_gen_pkg.sv
// sine_pkg: shared constants for the sine sample generator.
//   SAMPLES_PER_PERIOD : table entries per full sine period
//   QUARTER_LEN        : entries per quadrant (N/4)
//   QADDR_W            : address width of the quarter-wave table
//   DAC_W / MIDSCALE   : DAC code width and the zero-signal code
//   UNITY_GAIN         : gain value that leaves the wave unscaled
//   QUARTER_TABLE      : round(2047*sin(2*pi*k/200)), k = 0..50
package sine_pkg;
   localparam int SAMPLES_PER_PERIOD = 200;
   localparam int QUARTER_LEN        = SAMPLES_PER_PERIOD / 4;
   localparam int QADDR_W            = $clog2(QUARTER_LEN + 1);
   localparam int DAC_W              = 12;
   localparam int MIDSCALE           = 2048;
   localparam int UNITY_GAIN         = 256;

   localparam logic [DAC_W-1:0] QUARTER_TABLE [0:QUARTER_LEN] = '{
      12'd0,    12'd64,   12'd129,  12'd193,  12'd257,  12'd320,  12'd384,  12'd447,
      12'd509,  12'd571,  12'd633,  12'd693,  12'd754,  12'd813,  12'd872,  12'd929,
      12'd986,  12'd1042, 12'd1097, 12'd1151, 12'd1203, 12'd1255, 12'd1305, 12'd1354,
      12'd1401, 12'd1447, 12'd1492, 12'd1535, 12'd1577, 12'd1617, 12'd1656, 12'd1693,
      12'd1728, 12'd1762, 12'd1794, 12'd1824, 12'd1852, 12'd1879, 12'd1903, 12'd1926,
      12'd1947, 12'd1966, 12'd1983, 12'd1998, 12'd2011, 12'd2022, 12'd2031, 12'd2038,
      12'd2043, 12'd2046, 12'd2047
   };
endpackage

// File: rtl/sine_sample_gen_rom.sv
// sine_quarter_rom: registered quarter-wave lookup, one cycle of latency.
//   clk, rst_n : clock, async active-low reset
//   i_k        : quarter-table index 0..QUARTER_LEN
//   o_q        : |sin| magnitude Q[k], valid the cycle after i_k
module sine_quarter_rom
   import sine_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [QADDR_W-1:0] i_k,
   output logic [DAC_W-1:0]   o_q
);
   logic [DAC_W-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_q <= '0;
      else if (i_k <= QADDR_W'(QUARTER_LEN))
         r_q <= QUARTER_TABLE[i_k];
      else
         r_q <= '0;
   end

   assign o_q = r_q;
endmodule

// File: rtl/sine_sample_gen.sv
// sine_sample_gen: table-driven sine DAC sample generator with gain/offset.
//   clk, rst_n         : clock, async active-low reset
//   i_phase_index      : table index from the DAC sequencer
//   i_cfg_load         : strobe capturing i_cfg_gain/i_cfg_offset as pending
//   i_cfg_gain         : unsigned gain, 256 = unity, clamps above 256
//   i_cfg_offset       : signed DC offset in LSBs
//   o_current_sample   : offset-binary DAC code, held between updates
//   o_sample_valid     : one-cycle pulse when o_current_sample updates
//   o_cfg_pending      : loaded config waiting for the next index-0 sample
//   o_sat_flag         : pulses with o_sample_valid when the sample clipped
//   o_phase_err        : sticky, set by an out-of-range phase index
// Pipeline: detect -> stage 1 (ROM + sign/gain/offset) -> stage 2 (scale,
// add, clip), so a sample lands exactly 2 clocks after its index changed.
module sine_sample_gen
   import sine_pkg::*;
#(
   parameter int SAMPLES_PER_PERIOD = sine_pkg::SAMPLES_PER_PERIOD,
   parameter int GAIN_W             = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        i_phase_index,
   input  logic              i_cfg_load,
   input  logic [GAIN_W-1:0] i_cfg_gain,
   input  logic [11:0]       i_cfg_offset,
   output logic [11:0]       o_current_sample,
   output logic              o_sample_valid,
   output logic              o_cfg_pending,
   output logic              o_sat_flag,
   output logic              o_phase_err
);
   localparam int QL = SAMPLES_PER_PERIOD / 4;
   localparam int PW = DAC_W + 1 + GAIN_W + 1;

   // index tracking
   logic [7:0]          r_phase_q;
   logic                r_first;
   logic                w_new, w_oor, w_apply;
   logic [1:0]          w_quad;
   logic [7:0]          w_k, w_addr8;
   logic [QADDR_W-1:0]  w_rom_addr;
   // config
   logic [GAIN_W-1:0]   w_gain_clamp, r_pend_gain, r_act_gain, w_gain_use;
   logic signed [11:0]  r_pend_off, r_act_off, w_off_use;
   logic                r_cfg_pending;
   // pipeline
   logic [1:0]          r_vld_pipe;
   logic                r_s1_neg, r_s1_oor;
   logic [GAIN_W-1:0]   r_s1_gain;
   logic signed [11:0]  r_s1_off;
   logic [DAC_W-1:0]    w_q;
   logic signed [12:0]  w_s;
   logic signed [PW-1:0] w_prod, w_scaled;
   logic signed [14:0]  w_sum;
   logic [DAC_W-1:0]    w_clip;
   logic                w_clipped;
   logic [DAC_W-1:0]    r_sample;
   logic                r_sat, r_phase_err;

   // The first cycle after reset always counts as a new index so the
   // output is refreshed even if the sequencer is parked on one value.
   assign w_new   = r_first | (i_phase_index != r_phase_q);
   assign w_oor   = (i_phase_index >= 8'(SAMPLES_PER_PERIOD));
   assign w_apply = w_new & (i_phase_index == 8'd0) & r_cfg_pending;

   always_comb begin
      w_quad = 2'd0;
      w_k    = i_phase_index;
      if (i_phase_index >= 8'(3*QL)) begin
         w_quad = 2'd3;
         w_k    = i_phase_index - 8'(3*QL);
      end else if (i_phase_index >= 8'(2*QL)) begin
         w_quad = 2'd2;
         w_k    = i_phase_index - 8'(2*QL);
      end else if (i_phase_index >= 8'(QL)) begin
         w_quad = 2'd1;
         w_k    = i_phase_index - 8'(QL);
      end
   end

   // Odd quadrants read the table backwards; quadrants 2/3 are negated.
   assign w_addr8    = w_quad[0] ? (8'(QL) - w_k) : w_k;
   assign w_rom_addr = w_oor ? '0 : QADDR_W'(w_addr8);

   assign w_gain_clamp = (i_cfg_gain > GAIN_W'(UNITY_GAIN)) ? GAIN_W'(UNITY_GAIN) : i_cfg_gain;
   // The index-0 sample that triggers an apply already uses the new values.
   assign w_gain_use   = w_apply ? r_pend_gain : r_act_gain;
   assign w_off_use    = w_apply ? r_pend_off  : r_act_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase_q     <= '0;
         r_first       <= 1'b1;
         r_pend_gain   <= GAIN_W'(UNITY_GAIN);
         r_pend_off    <= '0;
         r_act_gain    <= GAIN_W'(UNITY_GAIN);
         r_act_off     <= '0;
         r_cfg_pending <= 1'b0;
         r_phase_err   <= 1'b0;
      end else begin
         r_phase_q <= i_phase_index;
         r_first   <= 1'b0;
         if (w_oor)
            r_phase_err <= 1'b1;
         if (w_apply) begin
            r_act_gain <= r_pend_gain;
            r_act_off  <= r_pend_off;
         end
         // A load coinciding with an apply becomes the next pending set.
         if (i_cfg_load) begin
            r_pend_gain   <= w_gain_clamp;
            r_pend_off    <= $signed(i_cfg_offset);
            r_cfg_pending <= 1'b1;
         end else if (w_apply) begin
            r_cfg_pending <= 1'b0;
         end
      end
   end

   sine_quarter_rom u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .i_k   (w_rom_addr),
      .o_q   (w_q)
   );

   // stage 1 side-band registers, parallel to the ROM read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_s1_neg   <= 1'b0;
         r_s1_oor   <= 1'b0;
         r_s1_gain  <= GAIN_W'(UNITY_GAIN);
         r_s1_off   <= '0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[0], w_new};
         r_s1_neg   <= w_quad[1];
         r_s1_oor   <= w_oor;
         r_s1_gain  <= w_gain_use;
         r_s1_off   <= w_off_use;
      end
   end

   // stage 2: scale with floor shift, add midscale and offset, clip
   assign w_s      = r_s1_neg ? -$signed({1'b0, w_q}) : $signed({1'b0, w_q});
   assign w_prod   = PW'(w_s) * $signed(PW'({1'b0, r_s1_gain}));
   assign w_scaled = w_prod >>> 8;
   assign w_sum    = 15'(w_scaled) + 15'(r_s1_off) + 15'(MIDSCALE);

   always_comb begin
      w_clip    = w_sum[DAC_W-1:0];
      w_clipped = 1'b0;
      if (w_sum < 15'sd0) begin
         w_clip    = '0;
         w_clipped = 1'b1;
      end else if (w_sum > 15'(2**DAC_W - 1)) begin
         w_clip    = '1;
         w_clipped = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample <= DAC_W'(MIDSCALE);
         r_sat    <= 1'b0;
      end else begin
         r_sat <= 1'b0;
         if (r_vld_pipe[0]) begin
            r_sample <= r_s1_oor ? DAC_W'(MIDSCALE) : w_clip;
            r_sat    <= ~r_s1_oor & w_clipped;
         end
      end
   end

   assign o_current_sample = r_sample;
   assign o_sample_valid   = r_vld_pipe[1];
   assign o_cfg_pending    = r_cfg_pending;
   assign o_sat_flag       = r_sat;
   assign o_phase_err      = r_phase_err;
endmodule

// File: tb/tb_sine_sample_gen.sv
// Directed bench for sine_sample_gen: a vector table at unity gain, hand
// sequences for config load/apply, saturation, out-of-range, reset, and a
// full-period sweep against a $sin-based golden model.
module tb_sine_sample_gen;
   localparam real PI = 3.14159265358979;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  phase_index = 8'd0;
   logic        cfg_load = 1'b0;
   logic [8:0]  cfg_gain = 9'd256;
   logic [11:0] cfg_offset = 12'd0;
   logic [11:0] current_sample;
   logic        sample_valid, cfg_pending, sat_flag, phase_err;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic [7:0] ph;
      int         exp_s;
      int         exp_sat;
   } vec_t;
   vec_t tbl [10];
   int   outv [200];

   sine_sample_gen #(.SAMPLES_PER_PERIOD(200), .GAIN_W(9)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_phase_index    (phase_index),
      .i_cfg_load       (cfg_load),
      .i_cfg_gain       (cfg_gain),
      .i_cfg_offset     (cfg_offset),
      .o_current_sample (current_sample),
      .o_sample_valid   (sample_valid),
      .o_cfg_pending    (cfg_pending),
      .o_sat_flag       (sat_flag),
      .o_phase_err      (phase_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [8:0] g, input logic [11:0] o);
      cfg_gain = g; cfg_offset = o; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   // Change the index (optionally with a coincident cfg_load) and expect the
   // sample exactly two clocks later, not one.
   task automatic step_ld(input string nm, input logic [7:0] ph, input bit ld,
                          input logic [8:0] g, input logic [11:0] o,
                          input int exp_s, input int exp_sat);
      phase_index = ph; cfg_load = ld; cfg_gain = g; cfg_offset = o;
      tick();
      cfg_load = 1'b0;
      chk({nm, " early valid"}, int'(sample_valid), 0);
      tick();
      chk({nm, " valid"}, int'(sample_valid), 1);
      chk({nm, " sample"}, int'(current_sample), exp_s);
      chk({nm, " sat"}, int'(sat_flag), exp_sat);
   endtask

   task automatic step(input string nm, input logic [7:0] ph, input int exp_s, input int exp_sat);
      step_ld(nm, ph, 1'b0, 9'd0, 12'd0, exp_s, exp_sat);
   endtask

   function automatic int qv(input int k);
      return $rtoi(2047.0 * $sin(2.0 * PI * k / 200.0) + 0.5);
   endfunction

   function automatic int golden(input int i, input int g, input int o);
      int q, k, s, r;
      q = i / 50;
      k = i % 50;
      case (q)
         0:       s =  qv(k);
         1:       s =  qv(50 - k);
         2:       s = -qv(k);
         default: s = -qv(50 - k);
      endcase
      r = 2048 + $rtoi($floor(real'(s) * real'(g) / 256.0)) + o;
      if (r < 0)    r = 0;
      if (r > 4095) r = 4095;
      return r;
   endfunction

   initial begin
      int nvalid, viol;
      tbl[0] = '{8'd0,   2048, 0};
      tbl[1] = '{8'd50,  4095, 0};
      tbl[2] = '{8'd150, 1,    0};
      tbl[3] = '{8'd25,  3495, 0};
      tbl[4] = '{8'd75,  3495, 0};
      tbl[5] = '{8'd125, 601,  0};
      tbl[6] = '{8'd175, 601,  0};
      tbl[7] = '{8'd100, 2048, 0};
      tbl[8] = '{8'd199, 1984, 0};
      tbl[9] = '{8'd1,   2112, 0};

      // reset state
      tick(); tick();
      chk("rst sample",  int'(current_sample), 2048);
      chk("rst valid",   int'(sample_valid), 0);
      chk("rst sat",     int'(sat_flag), 0);
      chk("rst pending", int'(cfg_pending), 0);
      chk("rst perr",    int'(phase_err), 0);
      rst_n = 1'b1;

      // unity gain, zero offset
      for (int i = 0; i < 10; i++)
         step($sformatf("tbl%0d", i), tbl[i].ph, tbl[i].exp_s, tbl[i].exp_sat);

      // gain change waits for the index-0 boundary
      step("p37", 8'd37, 3927, 0);
      load(9'd128, 12'd0);
      chk("load pending", int'(cfg_pending), 1);
      chk("load no valid", int'(sample_valid), 0);
      step("g128 pre", 8'd50, 4095, 0);
      chk("pre pending", int'(cfg_pending), 1);
      step("g128 wrap", 8'd0, 2048, 0);
      chk("wrap pending", int'(cfg_pending), 0);
      step("g128 p50", 8'd50, 3071, 0);
      step("g128 p150", 8'd150, 1024, 0);

      // positive offset and saturation
      load(9'd256, 12'd100);
      step("off p0", 8'd0, 2148, 0);
      step("off p50", 8'd50, 4095, 1);
      step("off p150", 8'd150, 101, 0);
      step("off p0b", 8'd0, 2148, 0);

      // gain above unity clamps
      load(9'd300, 12'd0);
      step("clamp pre", 8'd25, 3595, 0);
      step("clamp wrap", 8'd0, 2048, 0);
      step("clamp p25", 8'd25, 3495, 0);

      // second load overwrites the first
      load(9'd128, 12'd0);
      load(9'd64, 12'd0);
      step("ovw pre", 8'd50, 4095, 0);
      step("ovw wrap", 8'd0, 2048, 0);
      step("ovw p50", 8'd50, 2559, 0);

      // load coincident with apply
      load(9'd128, 12'd10);
      step_ld("coin wrap", 8'd0, 1'b1, 9'd256, -12'sd100, 2058, 0);
      chk("coin pending", int'(cfg_pending), 1);
      step("coin p50", 8'd50, 3081, 0);
      step("coin wrap2", 8'd0, 1948, 0);
      chk("coin2 pending", int'(cfg_pending), 0);
      step("neg clip", 8'd150, 0, 1);

      // back-to-back index changes
      phase_index = 8'd50; tick();
      phase_index = 8'd25; tick();
      chk("b2b0 valid", int'(sample_valid), 1);
      chk("b2b0 sample", int'(current_sample), 3995);
      phase_index = 8'd0; tick();
      chk("b2b1 valid", int'(sample_valid), 1);
      chk("b2b1 sample", int'(current_sample), 3395);
      tick();
      chk("b2b2 valid", int'(sample_valid), 1);
      chk("b2b2 sample", int'(current_sample), 1948);
      tick();
      chk("b2b idle", int'(sample_valid), 0);
      chk("b2b hold", int'(current_sample), 1948);

      // out-of-range index
      step("oor", 8'd210, 2048, 0);
      chk("oor perr", int'(phase_err), 1);
      step("oor after", 8'd50, 3995, 0);
      chk("oor sticky", int'(phase_err), 1);

      // reset with a sample in flight
      phase_index = 8'd150; tick();
      rst_n = 1'b0; #1;
      chk("mid rst valid",  int'(sample_valid), 0);
      chk("mid rst sample", int'(current_sample), 2048);
      chk("mid rst perr",   int'(phase_err), 0);
      tick();
      chk("mid rst valid2", int'(sample_valid), 0);
      rst_n = 1'b1;
      tick();
      chk("post rst early", int'(sample_valid), 0);
      tick();
      chk("post rst valid", int'(sample_valid), 1);
      chk("post rst sample", int'(current_sample), 1);

      // full sweep, index 0 coincides with a new load
      load(9'd256, 12'd0);
      nvalid = 0;
      for (int c = 0; c <= 200; c++) begin
         if (c < 200) phase_index = 8'(c);
         cfg_load = (c == 0);
         cfg_gain = 9'd128;
         cfg_offset = 12'd0;
         tick();
         cfg_load = 1'b0;
         if (c >= 1) begin
            if (sample_valid) nvalid++;
            outv[c-1] = int'(current_sample);
            chk($sformatf("sweep%0d", c-1), int'(current_sample), golden(c-1, 256, 0));
         end
      end
      tick();
      chk("sweep tail valid", int'(sample_valid), 0);
      chk("sweep count", nvalid, 200);
      viol = 0;
      for (int i = 0; i < 100; i++)
         if (outv[i] + outv[i+100] != 4096) viol++;
      chk("sweep symmetry", viol, 0);
      chk("sweep pending", int'(cfg_pending), 1);
      step("sweep wrap", 8'd0, 2048, 0);
      step("sweep g128", 8'd50, 3071, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/sine_sample_gen.md
SINE_SAMPLE_GEN -- requirements
Module: sine_sample_gen

Interface
REQ-001 Parameter SAMPLES_PER_PERIOD, default 200, meaning table entries per sine period (multiple of 4).
REQ-002 Parameter GAIN_W, default 9, meaning gain width (256 = unity).
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 phase_index  input  8  table index from DAC sequencer, 0..SAMPLES_PER_PERIOD-1.
REQ-006 cfg_load  input  1  one-cycle strobe capturing cfg_gain/cfg_offset into pending registers.
REQ-007 cfg_gain  input  GAIN_W  unsigned amplitude gain, 0..256 (values >256 clamp to 256).
REQ-008 cfg_offset  input  12  signed DC offset in LSBs.
REQ-009 current_sample  output  12  unsigned offset-binary DAC code.
REQ-010 sample_valid  output  1  one-cycle pulse when current_sample updates.
REQ-011 cfg_pending  output  1  high while a loaded config awaits period boundary.
REQ-012 sat_flag  output  1  high with sample_valid if current sample clipped.
REQ-013 phase_err  output  1  sticky; set on phase_index >= SAMPLES_PER_PERIOD.

Function
REQ-014 Registered phase_q tracks phase_index each cycle; a new index is detected when phase_index != phase_q, or on the first cycle after reset.
REQ-015 Quarter-wave table Q[k] = round(2047*sin(2*pi*k/SAMPLES_PER_PERIOD)), k = 0..N/4 inclusive (51 entries at default).
REQ-016 For index i: quadrant q = i/(N/4), k = i mod (N/4); s = +Q[k] (q0), +Q[N/4-k] (q1), -Q[k] (q2), -Q[N/4-k] (q3); s is signed 13-bit.
REQ-017 Scaled value = (s * gain_active) arithmetic-shifted right 8 (floor); gain_active = 256 gives s unchanged.
REQ-018 Result = 2048 + scaled + offset_active, computed at 15-bit signed; clip to 0..4095; sat_flag = 1 when clipped.
REQ-019 Pipeline: stage 1 registers ROM lookup and sign; stage 2 registers scaled, offset, and saturated result; current_sample and sample_valid update exactly 2 clk after the new-index detect.
REQ-020 Back-to-back index changes on consecutive cycles each produce their own sample_valid, in order.
REQ-021 current_sample holds its value between sample_valid pulses.
REQ-022 cfg_load captures pending_gain/pending_offset and sets cfg_pending; a later cfg_load before apply overwrites pending values.
REQ-023 Apply: on a new-index detect with phase_index == 0 and cfg_pending = 1, active <= pending, cfg_pending clears; that index-0 sample uses the new values.
REQ-024 cfg_load in the same cycle as apply: the previous pending values are applied; new values become pending; cfg_pending stays 1.
REQ-025 Out-of-range index: sample forced to 2048, sat_flag 0, phase_err set; no config apply.

Reset
REQ-026 During rst_n low: current_sample = 2048, sample_valid = 0, sat_flag = 0, cfg_pending = 0, phase_err = 0, gain_active = 256, offset_active = 0, pipeline valid bits cleared.
REQ-027 Reset mid-pipeline discards in-flight samples; no sample_valid until a new-index detect after release.

Structure
REQ-028 Package sine_pkg holds SAMPLES_PER_PERIOD, QUARTER_LEN, DAC_W = 12, MIDSCALE = 2048, UNITY_GAIN = 256, and the quarter-table constant.
REQ-029 Sub-module sine_quarter_rom: registered read, k -> Q[k], 1-cycle latency, forms pipeline stage 1.
REQ-030 Expected RTL size is 150-300 lines total.

Verification
REQ-031 Reset, then phase 0, unity gain, offset 0 -> current_sample 2048, 2 clk after change.
REQ-032 Phase 50 -> 4095; phase 150 -> 1; phase 25 -> 3495 (2048+1447); phase 75 -> 3495.
REQ-033 cfg_load gain 128 while phase is 37 -> cfg_pending 1, phase 50 still 4095; after wrap to 0, phase 50 -> 3071, phase 150 -> 1024, cfg_pending 0.
REQ-034 Offset +100, unity gain, phase 50 -> 4095 with sat_flag 1; phase 0 -> 2148 with sat_flag 0.
REQ-035 Phase 210 -> current_sample 2048 and phase_err 1; phase_err stays set until rst_n.
REQ-036 Full sweep 0..199 -> 200 sample_valid pulses; output matches the golden model, is odd-symmetric about 2048, and cfg_load coincident with the index-0 apply follows REQ-024.
